// File: rtl/class_arbiter_pkg.sv
// Shared definitions for the two-class weighted arbiter: FSM states, default
// word width and the turn-handover rule used when a service turn finishes.
package class_pkg;

  localparam int DEFAULT_DATA_SIZE = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_e;

  // A finished turn hands over to the other class first, otherwise keeps
  // serving the same class, otherwise parks in IDLE.
  function automatic arb_state_e turn_next(arb_state_e own, arb_state_e other,
                                           logic own_elig, logic other_elig);
    if (other_elig)
      return other;
    else if (own_elig)
      return own;
    else
      return IDLE;
  endfunction

endpackage

// File: rtl/class_arbiter_if.sv
// Bundle between the arbiter and its two class FIFOs plus the downstream sink.
// master = FIFO/sink environment side, slave = arbiter side.
interface class_arbiter_if #(parameter int DATA_SIZE = class_pkg::DEFAULT_DATA_SIZE);

  logic [DATA_SIZE-1:0] fifo0_data;
  logic [DATA_SIZE-1:0] fifo1_data;
  logic                 fifo0_empty;
  logic                 fifo1_empty;
  logic                 fifo0_error;
  logic                 fifo1_error;
  logic                 almost_full0;
  logic                 almost_full1;
  logic                 dest_pause;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 grant;

  modport master (
    output fifo0_data, fifo1_data, fifo0_empty, fifo1_empty,
           fifo0_error, fifo1_error, almost_full0, almost_full1, dest_pause,
    input  pop0, pop1, data_out, valid_out, grant
  );

  modport slave (
    input  fifo0_data, fifo1_data, fifo0_empty, fifo1_empty,
           fifo0_error, fifo1_error, almost_full0, almost_full1, dest_pause,
    output pop0, pop1, data_out, valid_out, grant
  );

endinterface

// File: rtl/class_arbiter_credit_cnt.sv
// Per-turn credit counter: counts pops within a turn and flags the pop that
// uses the last credit of the current class weight.
module arb_credit_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clearing wins over incrementing so a terminal pop restarts the next turn at zero.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign terminal = (count_q == limit - 1'b1);

endmodule

// File: rtl/class_arbiter.sv
// Two-class weighted round-robin FIFO arbiter with 1-cycle output latency.
// Optional urgency handover on almost-full is enabled with `define ARB_URGENT_EN.
module class_arbiter
  import class_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int W0        = 3,
  parameter int W1        = 1,
  parameter int CNT_W     = 4
) (
  input logic            clk,
  input logic            reset,
  class_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] W0_C = CNT_W'(W0);
  localparam logic [CNT_W-1:0] W1_C = CNT_W'(W1);

  arb_state_e           state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 grant_q, grant_d;
  logic                 elig0, elig1;
  logic                 urgent0, urgent1;
  logic                 pop0_c, pop1_c;
  logic                 credit_inc, credit_clr, credit_term;
  logic [CNT_W-1:0]     credit_limit;
  logic [DATA_SIZE-1:0] word_mux;

  // A zero weight makes its class permanently ineligible.
  assign elig0 = !bus.fifo0_empty && !bus.fifo0_error && (W0 != 0);
  assign elig1 = !bus.fifo1_empty && !bus.fifo1_error && (W1 != 0);

`ifdef ARB_URGENT_EN
  assign urgent0 = bus.almost_full0 && elig0;
  assign urgent1 = bus.almost_full1 && elig1;
`else
  logic unused_almost_full;
  assign unused_almost_full = bus.almost_full0 ^ bus.almost_full1;
  assign urgent0 = 1'b0;
  assign urgent1 = 1'b0;
`endif

  assign credit_limit = (state_q == SERVE1) ? W1_C : W0_C;

  arb_credit_cnt #(.CNT_W(CNT_W)) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (credit_inc),
    .clr      (credit_clr),
    .limit    (credit_limit),
    .terminal (credit_term)
  );

  // Only the other class's urgency ends a turn early; the pop of this cycle still happens.
  always_comb begin
    state_d    = state_q;
    pop0_c     = 1'b0;
    pop1_c     = 1'b0;
    credit_inc = 1'b0;
    credit_clr = 1'b0;
    if (!reset && !bus.dest_pause) begin
      unique case (state_q)
        IDLE: begin
          if (elig0)
            state_d = SERVE0;
          else if (elig1)
            state_d = SERVE1;
        end
        SERVE0: begin
          pop0_c     = elig0;
          credit_inc = elig0;
          if (!elig0 || credit_term || urgent1) begin
            credit_clr = 1'b1;
            state_d    = turn_next(SERVE0, SERVE1, elig0, elig1);
          end
        end
        SERVE1: begin
          pop1_c     = elig1;
          credit_inc = elig1;
          if (!elig1 || credit_term || urgent0) begin
            credit_clr = 1'b1;
            state_d    = turn_next(SERVE1, SERVE0, elig1, elig0);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = pop0_c | pop1_c;
    grant_d = pop1_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign word_mux      = grant_q ? bus.fifo1_data : bus.fifo0_data;
  assign bus.data_out  = word_mux;
  assign bus.valid_out = valid_q;
  assign bus.grant     = grant_q;
  assign bus.pop0      = pop0_c;
  assign bus.pop1      = pop1_c;

endmodule

// File: doc/class_arbiter.md
CLASS_ARBITER -- requirements
Module: class_arbiter

Interface
REQ-001 The block SHALL have these parameters:
  - DATA_SIZE, default 10, word width.
  - W0, default 3, class-0 pops per turn.
  - W1, default 1, class-1 pops per turn.
  - CNT_W, default 4, credit counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk  in  1  single clock, rising edge.
  - reset  in  1  synchronous, active-high reset.
  - fifo0_data  in  DATA_SIZE  class-0 FIFO read data, valid the cycle after pop0.
  - fifo1_data  in  DATA_SIZE  class-1 FIFO read data, valid the cycle after pop1.
  - fifo0_empty, fifo1_empty  in  1  FIFO empty flags.
  - fifo0_error, fifo1_error  in  1  FIFO error flags; an erroring FIFO is ineligible.
  - almost_full0, almost_full1  in  1  FIFO almost-full flags.
  - dest_pause  in  1  downstream backpressure.
  - pop0, pop1  out  1  FIFO read strobes, combinational.
  - data_out  out  DATA_SIZE  arbitrated word.
  - valid_out  out  1  data_out qualifier.
  - grant  out  1  registered class of the word on data_out.

Function
REQ-003 eligN SHALL equal !fifoN_empty && !fifoN_error.
REQ-004 The FSM SHALL have exactly the states IDLE, SERVE0 and SERVE1, and a credit counter of CNT_W bits.
REQ-005 From IDLE, the FSM SHALL go to SERVE0 if elig0, else to SERVE1 if elig1, else stay in IDLE; no pop SHALL occur in IDLE.
REQ-006 In SERVEn with eligN and !dest_pause, popN SHALL be 1 and credit SHALL increment.
REQ-007 In SERVEn, pop0 and pop1 SHALL never both be 1.
REQ-008 A turn SHALL end on the pop where credit == Wn-1, or in any cycle with !eligN; credit SHALL then clear.
REQ-009 At turn end, the next state SHALL be the other SERVE state if the other class is eligible, else the same SERVE state if it is still eligible, else IDLE.
REQ-010 With dest_pause=1, no pop SHALL occur, and state and credit SHALL hold.
REQ-011 valid_out SHALL be a register of (pop0|pop1), and grant SHALL be a register of pop1, giving 1-cycle latency.
REQ-012 data_out SHALL be grant ? fifo1_data : fifo0_data.
REQ-013 A pop on a FIFO's last entry SHALL produce one idle cycle before leaving the turn; this bubble is the required behaviour.
REQ-014 An error flag asserting mid-turn SHALL end the turn in that cycle, with no pop from that FIFO.
REQ-015 For Wn=0, class n SHALL never be served.

Reset
REQ-016 While reset=1 at a rising edge, the following SHALL hold:
  - state = IDLE, credit = 0;
  - valid_out = 0, grant = 0;
  - pop0 = pop1 = 0 combinationally.
REQ-017 A reset asserted mid-turn SHALL discard the turn; any in-flight word SHALL not be output.

Configuration
REQ-018 With ARB_URGENT_EN defined, almost_fullM with eligM while in SERVEn (M≠n) SHALL end the turn after the current cycle's pop, clear credit and go to SERVEm.
REQ-019 Urgency SHALL never preempt an urgent class's own turn.
REQ-020 Without ARB_URGENT_EN, almost_full0 and almost_full1 SHALL be unused, and behaviour SHALL be pure weighted round-robin.

Structure
REQ-021 A shared package class_pkg SHALL hold the state encoding constants (IDLE, SERVE0, SERVE1) and the default DATA_SIZE.
REQ-022 The credit counter with terminal-count compare SHALL be one sub-module, arb_credit_cnt.

Verification
REQ-023 The bench SHALL cover these scenarios with W0=3, W1=1:
  - Preload fifo0 with 0FF, 0EE, 0BB, 0AA and fifo1 with 3DD, 3CC -> data_out order 0FF, 0EE, 0BB, 3DD, 0AA, 3CC, with valid_out gap-free except REQ-013 bubbles.
  - fifo1 only, holding 399, 388, 377 -> three consecutive words, grant=1, each 1 cycle after its pop1.
  - dest_pause=1 for 5 cycles mid-turn -> no pops, credit frozen; the sequence resumes unchanged after release.
  - fifo0_error=1 while fifo0 non-empty -> pop0 never asserts; only class-1 words are output.
  - reset=1 for one cycle mid-SERVE0 -> next cycle state IDLE, valid_out=0; arbitration restarts at class 0.
  - ARB_URGENT_EN defined, almost_full1=1 during a class-0 turn after one pop -> the next pop is pop1.
